fpu_fma_sequencer: RTL and testbench
====================================

FPU_FMA_SEQUENCER -- requirements
Module: fpu_fma_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the max cycles to wait for a unit done before aborting (legal range 2..255).
REQ-002 SHALL have port CLK, input, 1, the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port RST, input, 1, the reset, which is asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, sequencer can accept a request.
REQ-006 SHALL have port req_select, input, 3, decoded class: 0=OP-FP, 1=FMADD, 2=FMSUB, 3=FNMADD, 4=FNMSUB.
REQ-007 SHALL have port req_op, input, 5, funct5 for OP-FP: 00000 FADD, 00001 FSUB, 00010 FMUL.
REQ-008 SHALL have ports req_rs1, req_rs2 and req_rs3, input, 16 each, half-precision operands.
REQ-009 SHALL have ports mul_start (output, 1), mul_a and mul_b (output, 16 each), mul_done (input, 1) and mul_result (input, 16), connecting to the shared multiplier.
REQ-010 SHALL have ports add_start (output, 1), add_a and add_b (output, 16 each), add_done (input, 1) and add_result (input, 16), connecting to the shared adder.
REQ-011 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_data (output, 16), resp_illegal (output, 1) and resp_timeout (output, 1).

Function
REQ-012 SHALL implement states IDLE, MUL, ADD and RESP.
REQ-013 SHALL drive req_ready=1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 at a rising edge, and that edge SHALL capture req_select, req_op, rs1, rs2 and rs3 into internal registers.
REQ-014 SHALL route accepted requests as follows:
- select 1-4 -> MUL
- select 0 with op FMUL -> MUL
- select 0 with op FADD or FSUB -> ADD
- any other select/op -> RESP with resp_illegal=1 and resp_data=0x7E00.
REQ-015 SHALL pulse mul_start or add_start for exactly one cycle, in the first cycle of MUL or ADD respectively.
REQ-016 SHALL hold mul_a/mul_b and add_a/add_b stable for the whole state, and SHALL drive them to 0 outside their state.
REQ-017 SHALL set the multiplier operands to mul_a=rs1 and mul_b=rs2.
REQ-018 SHALL ignore mul_done and add_done in the start cycle; they are sampled in each later cycle of the wait state.
REQ-019 SHALL, on mul_done in MUL, capture P=mul_result and act as follows:
- FMUL -> RESP with resp_data=P
- select 1-4 -> ADD.
REQ-020 SHALL drive adder operands per op (bit 15 is the sign):
- FADD: add_a=rs1, add_b=rs2
- FSUB: add_a=rs1, add_b=rs2 with bit 15 inverted
- FMADD: add_a=P, add_b=rs3
- FMSUB: add_a=P, add_b=~rs3[15]
- FNMSUB: add_a=~P[15], add_b=rs3
- FNMADD: add_a=~P[15], add_b=~rs3[15].
REQ-021 SHALL, on add_done in ADD, register add_result into resp_data and move to RESP.
REQ-022 SHALL drive resp_valid=1 only in RESP, holding resp_data and the flags stable until resp_ready=1, then return to IDLE on the next edge.
REQ-023 SHALL not accept a new request in the RESP-to-IDLE cycle, since req_ready is 0 in RESP.
REQ-024 SHALL reset an 8-bit wait counter to 0 on entry to MUL or ADD and increment it each cycle.
REQ-025 SHALL, if the wait counter reaches TIMEOUT-1 without a done, go to RESP with resp_timeout=1 and resp_data=0x7E00.
REQ-026 SHALL ignore a done arriving in the same cycle as the timeout: the timeout wins.
REQ-027 SHALL ignore mul_done and add_done outside their wait states, with no state change.
REQ-028 SHALL give a FADD/FSUB/FMUL latency, from the accept edge to resp_valid, of unit latency + 2 cycles.
REQ-029 SHALL give a fused-op latency of mul latency + add latency + 3 cycles.

Reset
REQ-030 SHALL, while RST=1 and regardless of the clock, force:
- state=IDLE, wait counter=0
- req_ready=0, mul_start=0, add_start=0, resp_valid=0
- resp_data=0, resp_illegal=0, resp_timeout=0
- all operand outputs 0.
REQ-031 SHALL abandon any in-flight operation when RST is asserted mid-operation, with no response produced.
REQ-032 SHALL have req_ready=1 in the first cycle after RST deasserts.

Verification
REQ-033 FMADD with rs1=0x4000, rs2=0x4200, rs3=0x3C00, and the model mul returning 0x4600 after 2 cycles -> add_a=0x4600, add_b=0x3C00; the model add returns 0x4700 -> resp_data=0x4700 with no flags.
REQ-034 FNMADD with the same operands -> add_a=0xC600, add_b=0xBC00.
REQ-035 FSUB with rs1=0x4200, rs2=0x3C00 -> mul_start is never asserted, add_b=0xBC00, and resp arrives at add latency + 2.
REQ-036 select=0, op=00011 -> resp_valid with resp_illegal=1 and resp_data=0x7E00; no unit is started.
REQ-037 TIMEOUT=8 with mul_done never asserted -> resp_timeout=1 exactly 8 cycles after the MUL entry cycle, and a late mul_done is then ignored.
REQ-038 Hold resp_ready=0 for 5 cycles -> resp_data stays stable; assert RST mid-ADD -> all outputs go to 0 immediately and req_ready=1 after release.

Source files
------------

// File: rtl/fpu_fma_sequencer.sv
// Half-precision FMA sequencer: steers OP-FP and fused multiply-add requests
// through a shared multiplier and a shared adder, with a per-unit wait
// timeout and a held response handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; captures operands on handshake
// MUL    | multiplier started in first cycle, waiting for mul_done
// ADD    | adder started in first cycle, waiting for add_done
// RESP   | response presented, held until resp_ready
module fpu_fma_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_select,
  input  logic [4:0]  req_op,
  input  logic [15:0] req_rs1,
  input  logic [15:0] req_rs2,
  input  logic [15:0] req_rs3,
  output logic        mul_start,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic        add_start,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic        add_done,
  input  logic [15:0] add_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_illegal,
  output logic        resp_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] SIGN    = 16'h8000;
  localparam logic [7:0]  WAIT_TC = 8'(TIMEOUT - 1);
  localparam logic [4:0]  OP_FADD = 5'b00000;
  localparam logic [4:0]  OP_FSUB = 5'b00001;
  localparam logic [4:0]  OP_FMUL = 5'b00010;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] rs1_q, rs1_d;
  logic [15:0] rs2_q, rs2_d;
  logic [15:0] rs3_q, rs3_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] data_q, data_d;
  logic        ill_q, ill_d;
  logic        to_q, to_d;

  logic        req_fused, req_fmul, req_fadd_sub;
  logic        tc_hit, done_window;
  logic [15:0] add_a_v, add_b_v;

  assign req_fused    = (req_select >= 3'd1) && (req_select <= 3'd4);
  assign req_fmul     = (req_select == 3'd0) && (req_op == OP_FMUL);
  assign req_fadd_sub = (req_select == 3'd0) && ((req_op == OP_FADD) || (req_op == OP_FSUB));

  // The timeout compare wins over a done in the same cycle; the start cycle
  // (count 0) never samples done.
  assign tc_hit      = (cnt_q == WAIT_TC);
  assign done_window = (cnt_q != 8'd0) && !tc_hit;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      op_q    <= 5'd0;
      rs1_q   <= 16'h0;
      rs2_q   <= 16'h0;
      rs3_q   <= 16'h0;
      prod_q  <= 16'h0;
      data_q  <= 16'h0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      prod_q  <= prod_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  // Next-state, wait counter and capture of operands/results.
  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    sel_d   = sel_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    prod_d  = prod_q;
    data_d  = data_q;
    ill_d   = ill_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          sel_d  = req_select;
          op_d   = req_op;
          rs1_d  = req_rs1;
          rs2_d  = req_rs2;
          rs3_d  = req_rs3;
          ill_d  = 1'b0;
          to_d   = 1'b0;
          data_d = 16'h0;
          if (req_fused || req_fmul) begin
            state_d = S_MUL;
          end else if (req_fadd_sub) begin
            state_d = S_ADD;
          end else begin
            state_d = S_RESP;
            ill_d   = 1'b1;
            data_d  = QNAN;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 8'd1;
        if (tc_hit) begin
          state_d = S_RESP;
          to_d    = 1'b1;
          data_d  = QNAN;
        end else if (done_window && mul_done) begin
          prod_d = mul_result;
          if (sel_q == 3'd0) begin
            state_d = S_RESP;
            data_d  = mul_result;
          end else begin
            state_d = S_ADD;
            cnt_d   = 8'd0;
          end
        end
      end
      S_ADD: begin
        cnt_d = cnt_q + 8'd1;
        if (tc_hit) begin
          state_d = S_RESP;
          to_d    = 1'b1;
          data_d  = QNAN;
        end else if (done_window && add_done) begin
          state_d = S_RESP;
          data_d  = add_result;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Adder operand selection: FSUB and the fused variants differ only in
  // which sign bits get flipped on the product and the addend.
  always_comb begin
    add_a_v = 16'h0;
    add_b_v = 16'h0;
    unique case (sel_q)
      3'd0: begin
        add_a_v = rs1_q;
        add_b_v = (op_q == OP_FSUB) ? (rs2_q ^ SIGN) : rs2_q;
      end
      3'd1: begin
        add_a_v = prod_q;
        add_b_v = rs3_q;
      end
      3'd2: begin
        add_a_v = prod_q;
        add_b_v = rs3_q ^ SIGN;
      end
      3'd3: begin
        add_a_v = prod_q ^ SIGN;
        add_b_v = rs3_q ^ SIGN;
      end
      3'd4: begin
        add_a_v = prod_q ^ SIGN;
        add_b_v = rs3_q;
      end
      default: begin
        add_a_v = 16'h0;
        add_b_v = 16'h0;
      end
    endcase
  end

  // req_ready is masked by RST so it stays low while the state is forced.
  assign req_ready    = (state_q == S_IDLE) && !RST;
  assign mul_start    = (state_q == S_MUL) && (cnt_q == 8'd0);
  assign add_start    = (state_q == S_ADD) && (cnt_q == 8'd0);
  assign mul_a        = (state_q == S_MUL) ? rs1_q : 16'h0;
  assign mul_b        = (state_q == S_MUL) ? rs2_q : 16'h0;
  assign add_a        = (state_q == S_ADD) ? add_a_v : 16'h0;
  assign add_b        = (state_q == S_ADD) ? add_b_v : 16'h0;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_data    = (state_q == S_RESP) ? data_q : 16'h0;
  assign resp_illegal = (state_q == S_RESP) && ill_q;
  assign resp_timeout = (state_q == S_RESP) && to_q;

endmodule

// File: tb/tb_fpu_fma_sequencer.sv
// Bench for fpu_fma_sequencer: directed vector table, randomized requests
// against a reference model, and hand-written reset/stall/done corner cases.
module tb_fpu_fma_sequencer;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [2:0]  req_select;
  logic [4:0]  req_op;
  logic [15:0] req_rs1, req_rs2, req_rs3;
  logic        mul_start, mul_done;
  logic [15:0] mul_a, mul_b, mul_result;
  logic        add_start, add_done;
  logic [15:0] add_a, add_b, add_result;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic        resp_illegal, resp_timeout;

  fpu_fma_sequencer #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_select(req_select), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_done(add_done), .add_result(add_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_illegal(resp_illegal), .resp_timeout(resp_timeout)
  );

  always #5 CLK = ~CLK;

  // ---------------- unit models (latency 0 = never answers) ----------------
  int          mdl_ml = 1, mdl_al = 1;
  logic [15:0] mdl_mres = 16'h0, mdl_ares = 16'h0;
  logic        inj_mdone = 1'b0, inj_adone = 1'b0;
  int          m_cnt = 0, a_cnt = 0, tot_mul = 0, tot_add = 0, stab_m = 0, stab_a = 0;
  logic [15:0] cap_ma = 16'h0, cap_mb = 16'h0, cap_aa = 16'h0, cap_ab = 16'h0;
  logic        mdl_mdone = 1'b0, mdl_adone = 1'b0;
  logic [15:0] mres_out = 16'h0, ares_out = 16'h0;

  assign mul_done   = mdl_mdone | inj_mdone;
  assign add_done   = mdl_adone | inj_adone;
  assign mul_result = mres_out;
  assign add_result = ares_out;

  always @(negedge CLK) begin
    if (m_cnt > 0) begin
      if (mul_a !== cap_ma || mul_b !== cap_mb) stab_m <= stab_m + 1;
      if (m_cnt == 1) begin
        mdl_mdone <= 1'b1;
        mres_out  <= mdl_mres;
      end else mdl_mdone <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else mdl_mdone <= 1'b0;
    if (mul_start === 1'b1) begin
      m_cnt   <= mdl_ml;
      cap_ma  <= mul_a;
      cap_mb  <= mul_b;
      tot_mul <= tot_mul + 1;
    end
  end

  always @(negedge CLK) begin
    if (a_cnt > 0) begin
      if (add_a !== cap_aa || add_b !== cap_ab) stab_a <= stab_a + 1;
      if (a_cnt == 1) begin
        mdl_adone <= 1'b1;
        ares_out  <= mdl_ares;
      end else mdl_adone <= 1'b0;
      a_cnt <= a_cnt - 1;
    end else mdl_adone <= 1'b0;
    if (add_start === 1'b1) begin
      a_cnt   <= mdl_al;
      cap_aa  <= add_a;
      cap_ab  <= add_b;
      tot_add <= tot_add + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{req_ready, mul_start, add_start, resp_valid, resp_illegal, resp_timeout,
             resp_data, mul_a, mul_b, add_a, add_b};
  endfunction

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  op;
    logic [15:0] rs1, rs2, rs3;
    int          ml, al;
    logic [15:0] mres, ares, exp_data;
    logic        exp_ill, exp_to;
    int          exp_lat;
    logic        chk_add;
    logic [15:0] exp_aa, exp_ab;
    int          exp_nm, exp_na;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] sel, input logic [4:0] op,
                              input logic [15:0] rs1, rs2, rs3, input int ml, al,
                              input logic [15:0] mres, ares, data, input logic ill, to,
                              input int lat, input logic ca, input logic [15:0] aa, ab,
                              input int nm, na);
    vec_t v;
    v.sel = sel; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.ml = ml; v.al = al; v.mres = mres; v.ares = ares; v.exp_data = data;
    v.exp_ill = ill; v.exp_to = to; v.exp_lat = lat; v.chk_add = ca;
    v.exp_aa = aa; v.exp_ab = ab; v.exp_nm = nm; v.exp_na = na;
    return v;
  endfunction

  // Reference model: latency counted in cycles from the accept cycle (0).
  // A unit answering L cycles after its start cycle is seen in time only if
  // L < TO-1; otherwise the wait expires TO cycles after the start cycle.
  function automatic vec_t ref_model(input logic [2:0] sel, input logic [4:0] op,
                                     input logic [15:0] rs1, rs2, rs3, input int ml, al,
                                     input logic [15:0] mres, ares);
    vec_t v;
    int   t;
    logic fused, use_mul, use_add;
    logic [15:0] a, b;
    v = mk(sel, op, rs1, rs2, rs3, ml, al, mres, ares, 16'h0, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 0, 0);
    fused = (sel >= 3'd1 && sel <= 3'd4);
    if (!fused && !(sel == 3'd0 && op <= 5'd2)) begin
      v.exp_data = 16'h7E00; v.exp_ill = 1'b1; v.exp_lat = 1;
      return v;
    end
    use_mul = fused || op == 5'd2;
    use_add = fused || op != 5'd2;
    t = 1;
    if (use_mul) begin
      v.exp_nm = 1;
      if (ml == 0 || ml >= TO - 1) begin
        v.exp_to = 1'b1; v.exp_data = 16'h7E00; v.exp_lat = t + TO;
        return v;
      end
      t = t + ml + 1;
    end
    if (use_add) begin
      a = fused ? mres : rs1;
      b = fused ? rs3 : rs2;
      if (sel == 3'd0 && op == 5'd1) b = b ^ 16'h8000;           // FSUB negates rs2
      if (sel == 3'd3 || sel == 3'd4) a = a ^ 16'h8000;           // FNM*: negated product
      if (sel == 3'd2 || sel == 3'd3) b = b ^ 16'h8000;           // subtracting rs3
      v.exp_na = 1; v.chk_add = 1'b1; v.exp_aa = a; v.exp_ab = b;
      if (al == 0 || al >= TO - 1) begin
        v.exp_to = 1'b1; v.exp_data = 16'h7E00; v.exp_lat = t + TO;
        return v;
      end
      t = t + al + 1;
      v.exp_data = ares;
    end else v.exp_data = mres;
    v.exp_lat = t;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 (accept cycle is 0).
  task automatic issue(input logic [2:0] sel, input logic [4:0] op,
                       input logic [15:0] a, b, c, input int ml, al,
                       input logic [15:0] mr, ar);
    int n;
    n = 0;
    mdl_ml = ml; mdl_al = al; mdl_mres = mr; mdl_ares = ar;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_select = sel; req_op = op;
    req_rs1 = a; req_rs2 = b; req_rs3 = c;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int m0, a0, lat;
    m0 = tot_mul;
    a0 = tot_add;
    issue(v.sel, v.op, v.rs1, v.rs2, v.rs3, v.ml, v.al, v.mres, v.ares);
    wait_resp(1, lat);
    chk({tag, "/latency"}, lat, v.exp_lat);
    chk({tag, "/resp_data"}, resp_data, v.exp_data);
    chk({tag, "/resp_illegal"}, resp_illegal, v.exp_ill);
    chk({tag, "/resp_timeout"}, resp_timeout, v.exp_to);
    chk({tag, "/req_ready_in_resp"}, req_ready, 1'b0);
    chk({tag, "/mul_starts"}, tot_mul - m0, v.exp_nm);
    chk({tag, "/add_starts"}, tot_add - a0, v.exp_na);
    if (v.chk_add) begin
      chk({tag, "/add_a"}, cap_aa, v.exp_aa);
      chk({tag, "/add_b"}, cap_ab, v.exp_ab);
    end
    @(negedge CLK);
    chk({tag, "/resp_valid_after"}, resp_valid, 1'b0);
    chk({tag, "/req_ready_after"}, req_ready, 1'b1);
    chk({tag, "/operands_idle"}, |{mul_a, mul_b, add_a, add_b}, 1'b0);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return TO - 1;
    return int'($urandom_range(1, 6));
  endfunction

  vec_t tbl[12];

  initial begin
    int lat, bad;
    vec_t v;
    logic [2:0] s;
    logic [4:0] o;

    tbl[0]  = mk(3'd1, 5'd0, 16'h4000, 16'h4200, 16'h3C00, 2, 1, 16'h4600, 16'h4700, 16'h4700, 0, 0, 6,  1, 16'h4600, 16'h3C00, 1, 1);
    tbl[1]  = mk(3'd3, 5'd0, 16'h4000, 16'h4200, 16'h3C00, 2, 1, 16'h4600, 16'h4700, 16'h4700, 0, 0, 6,  1, 16'hC600, 16'hBC00, 1, 1);
    tbl[2]  = mk(3'd0, 5'd1, 16'h4200, 16'h3C00, 16'h0000, 0, 3, 16'h0000, 16'h4000, 16'h4000, 0, 0, 5,  1, 16'h4200, 16'hBC00, 0, 1);
    tbl[3]  = mk(3'd0, 5'd3, 16'h4200, 16'h3C00, 16'h1111, 2, 2, 16'h4600, 16'h4700, 16'h7E00, 1, 0, 1,  0, 16'h0000, 16'h0000, 0, 0);
    tbl[4]  = mk(3'd0, 5'd2, 16'h3C00, 16'h4000, 16'h0000, 1, 0, 16'h4000, 16'h0000, 16'h4000, 0, 0, 3,  0, 16'h0000, 16'h0000, 1, 0);
    tbl[5]  = mk(3'd0, 5'd0, 16'h3C00, 16'h3C00, 16'h0000, 0, 6, 16'h0000, 16'h4000, 16'h4000, 0, 0, 8,  1, 16'h3C00, 16'h3C00, 0, 1);
    tbl[6]  = mk(3'd0, 5'd2, 16'h5000, 16'h5000, 16'h0000, 7, 0, 16'h1234, 16'h0000, 16'h7E00, 0, 1, 9,  0, 16'h0000, 16'h0000, 1, 0);
    tbl[7]  = mk(3'd2, 5'd0, 16'h4400, 16'hC000, 16'hBC00, 3, 2, 16'hC800, 16'hC900, 16'hC900, 0, 0, 8,  1, 16'hC800, 16'h3C00, 1, 1);
    tbl[8]  = mk(3'd4, 5'd0, 16'h3C00, 16'h4500, 16'h4000, 1, 1, 16'h4500, 16'hC700, 16'hC700, 0, 0, 5,  1, 16'hC500, 16'h4000, 1, 1);
    tbl[9]  = mk(3'd5, 5'd0, 16'h1234, 16'h5678, 16'h9ABC, 1, 1, 16'h1111, 16'h2222, 16'h7E00, 1, 0, 1,  0, 16'h0000, 16'h0000, 0, 0);
    tbl[10] = mk(3'd1, 5'd0, 16'h3C00, 16'h4100, 16'h3800, 1, 0, 16'h4100, 16'h0000, 16'h7E00, 0, 1, 11, 1, 16'h4100, 16'h3800, 1, 1);
    tbl[11] = mk(3'd0, 5'd0, 16'h4000, 16'hC000, 16'h0000, 0, 7, 16'h0000, 16'h1234, 16'h7E00, 0, 1, 9,  1, 16'h4000, 16'hC000, 0, 1);

    RST = 1'b1; req_valid = 1'b0; req_select = 3'd0; req_op = 5'd0;
    req_rs1 = 16'h0; req_rs2 = 16'h0; req_rs3 = 16'h0; resp_ready = 1'b1;
    #2;
    chk("reset/outputs_zero", any_out(), 1'b0);
    chk("reset/req_ready", req_ready, 1'b0);
    repeat (3) @(negedge CLK);
    req_valid = 1'b1;
    #1;
    chk("reset/held_through_clocks", any_out(), 1'b0);
    @(negedge CLK);
    req_valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("reset/req_ready_after_release", req_ready, 1'b1);
    @(negedge CLK);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // response held while resp_ready is low
    resp_ready = 1'b0;
    issue(3'd1, 5'd0, 16'h4000, 16'h4200, 16'h3C00, 2, 1, 16'h4600, 16'h4700);
    wait_resp(1, lat);
    chk("stall/latency", lat, 6);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (resp_valid !== 1'b1 || resp_data !== 16'h4700 || resp_illegal !== 1'b0 || resp_timeout !== 1'b0) bad++;
    end
    chk("stall/held_cycles_bad", bad, 0);
    resp_ready = 1'b1;
    @(negedge CLK);
    chk("stall/released", {resp_valid, req_ready}, 2'b01);

    // done in the start cycle is ignored; the wait then times out
    issue(3'd0, 5'd0, 16'h4000, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0);
    inj_adone = 1'b1;
    @(negedge CLK);
    inj_adone = 1'b0;
    wait_resp(2, lat);
    chk("startdone/latency", lat, 9);
    chk("startdone/timeout", {resp_timeout, resp_illegal}, 2'b10);
    chk("startdone/data", resp_data, 16'h7E00);
    @(negedge CLK);

    // multiplier never answers; late dones afterwards change nothing
    issue(3'd0, 5'd2, 16'h4000, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0);
    wait_resp(1, lat);
    chk("mul_timeout/latency", lat, TO + 1);
    chk("mul_timeout/flag", resp_timeout, 1'b1);
    inj_mdone = 1'b1;
    @(negedge CLK);
    chk("late_done/idle", {req_ready, resp_valid}, 2'b10);
    inj_adone = 1'b1;
    @(negedge CLK);
    inj_mdone = 1'b0;
    inj_adone = 1'b0;
    chk("late_done/still_idle", {req_ready, resp_valid, mul_start, add_start}, 4'b1000);
    @(negedge CLK);
    chk("late_done/no_resp", resp_valid, 1'b0);

    // reset in the middle of ADD
    issue(3'd0, 5'd0, 16'h4400, 16'h3C00, 16'h0000, 0, 0, 16'h0, 16'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("midreset/add_a_before", add_a, 16'h4400);
    RST = 1'b1;
    #1;
    chk("midreset/outputs_zero", any_out(), 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midreset/req_ready_after", req_ready, 1'b1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    chk("midreset/abandoned", bad, 0);

    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom_range(0, 7));
      if (s == 3'd0 && $urandom_range(0, 4) != 0) o = 5'($urandom_range(0, 2));
      else o = 5'($urandom);
      v = ref_model(s, o, 16'($urandom), 16'($urandom), 16'($urandom),
                    pick_lat(), pick_lat(), 16'($urandom), 16'($urandom));
      run_vec(v, $sformatf("rnd%0d", i));
    end

    chk("operand_stability", stab_m + stab_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
